// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - Framebuffer write scheduler: slot spacing, CPU/clear arbitration, phase counter
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   counter                  free-running 3-bit phase counter
//   cpu_valid/addr/data      CPU row write request; cpu_ready accepts it
//   clr_start, clr_data      start a fill of every row with clr_data; clr_busy while running
//   fb_w_addr, fb_data_in    registered row address/data to the framebuffer
//   fb_set_data              one-cycle write strobe, spaced >= BEAT_CYCLES apart
//   fb_busy                  framebuffer write window active
//
// Build option: FB_CLEAR_EN enables the bulk-clear engine and the round-robin
// arbiter; without it the CPU is the only requester and clr_* inputs are ignored.

module fb_write_scheduler #(
    parameter int ADDR_BITS   = 4,
    parameter int DATA_W      = 32,
    parameter int BEAT_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [2:0]           counter,
    input  logic                 cpu_valid,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]    cpu_data,
    output logic                 cpu_ready,
    input  logic                 clr_start,
    input  logic [DATA_W-1:0]    clr_data,
    output logic                 clr_busy,
    output logic [ADDR_BITS-1:0] fb_w_addr,
    output logic [DATA_W-1:0]    fb_data_in,
    output logic                 fb_set_data,
    output logic                 fb_busy
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEAT_CYCLES - 1);

    typedef enum logic [1:0] {GUARD, IDLE, WRITE} state_t;

    state_t        state;
    logic [BW-1:0] beat;      // guard countdown in GUARD, write beat in WRITE

    logic                 slot_open;
    logic                 grant_cpu;
    logic                 cpu_fire;
    logic                 clr_fire;
    logic                 fire;
    logic [ADDR_BITS-1:0] clr_addr;
    logic [DATA_W-1:0]    clr_wdata;

    // Final beat of a write is itself an open slot so grants can run back-to-back.
    assign slot_open = (state == IDLE) || ((state == WRITE) && (beat == LAST_BEAT));
    assign cpu_ready = slot_open && grant_cpu;
    assign cpu_fire  = cpu_ready && cpu_valid;
    assign fire      = cpu_fire || clr_fire;
    assign fb_busy   = (state == WRITE);

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_BITS:0] ROWS = (ADDR_BITS+1)'(1 << ADDR_BITS);

    logic                 clr_busy_q;
    logic [ADDR_BITS:0]   clr_row;         // rows already granted to the clear
    logic [DATA_W-1:0]    clr_pattern;
    logic                 last_grant_cpu;  // resets to CLR so the CPU wins the first tie
    logic                 cur_clr;         // write in flight belongs to the clear
    logic                 clr_req;

    assign clr_req   = clr_busy_q && (clr_row != ROWS);
    // Grant points at the CPU whenever the clear is not asking, so cpu_ready
    // can be high even with cpu_valid low.
    assign grant_cpu = !clr_req || (cpu_valid && !last_grant_cpu);
    assign clr_fire  = slot_open && clr_req && !grant_cpu;
    assign clr_addr  = clr_row[ADDR_BITS-1:0];
    assign clr_wdata = clr_pattern;
    assign clr_busy  = clr_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_busy_q     <= 1'b0;
            clr_row        <= '0;
            clr_pattern    <= '0;
            last_grant_cpu <= 1'b0;
            cur_clr        <= 1'b0;
        end else begin
            if (cpu_fire) begin
                last_grant_cpu <= 1'b1;
                cur_clr        <= 1'b0;
            end else if (clr_fire) begin
                last_grant_cpu <= 1'b0;
                cur_clr        <= 1'b1;
                clr_row        <= clr_row + 1'b1;
            end

            if (!clr_busy_q) begin
                if (clr_start) begin
                    clr_busy_q  <= 1'b1;
                    clr_pattern <= clr_data;
                    clr_row     <= '0;
                end
            end else if ((clr_row == ROWS) && cur_clr &&
                         (state == WRITE) && (beat == LAST_BEAT)) begin
                // Last clear row has finished its commit window.
                clr_busy_q <= 1'b0;
            end
        end
    end
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_data};
    assign grant_cpu  = 1'b1;
    assign clr_fire   = 1'b0;
    assign clr_addr   = '0;
    assign clr_wdata  = '0;
    assign clr_busy   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= 3'd0;
        end else begin
            counter <= counter + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GUARD;
            beat        <= '0;
            fb_set_data <= 1'b0;
            fb_w_addr   <= '0;
            fb_data_in  <= '0;
        end else begin
            fb_set_data <= fire;
            if (fire) begin
                fb_w_addr  <= cpu_fire ? cpu_addr : clr_addr;
                fb_data_in <= cpu_fire ? cpu_data : clr_wdata;
            end

            case (state)
                // Hold off grants long enough for a commit interrupted by reset to drain.
                GUARD: begin
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                IDLE: begin
                    if (fire) begin
                        state <= WRITE;
                        beat  <= '0;
                    end
                end
                WRITE: begin
                    if (beat == LAST_BEAT) begin
                        beat <= '0;
                        if (!fire) begin
                            state <= IDLE;
                        end
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= GUARD;
                    beat  <= '0;
                end
            endcase
        end
    end

endmodule
